// File: rtl/perf_trig_pkg.sv
// Shared definitions for the performance-counter trigger master.
// Holds the FSM state encoding, the control-slave address map and the
// command decode helper that maps a pending-flag index to an Avalon write.
package perf_trig_pkg;

    localparam int unsigned ADDR_W         = 4;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned CMD_IDX_W      = 4;   // indexes up to 2*4+1 pending flags
    localparam int unsigned SECTION_STRIDE = 4;

    localparam logic [ADDR_W-1:0] STOP_OFS   = 4'd0;
    localparam logic [ADDR_W-1:0] GO_OFS     = 4'd1;
    localparam logic [DATA_W-1:0] CLEAR_DATA = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_HOLD  = 2'd2
    } trig_state_e;

    // One write on the control slave.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } avm_cmd_t;

    // Pending index layout: 0 = clear, 1..N = stop[0..N-1], N+1..2N = start[0..N-1].
    function automatic avm_cmd_t decode_cmd(input logic [CMD_IDX_W-1:0] idx,
                                            input int unsigned num_sections);
        avm_cmd_t    cmd;
        int unsigned i;
        int unsigned s;
        cmd.addr = '0;
        cmd.data = '0;
        i        = 32'(idx);
        s        = 0;
        if (i == 0) begin
            cmd.data = CLEAR_DATA;
        end else if (i <= num_sections) begin
            s        = i - 1;
            cmd.addr = ADDR_W'(s * SECTION_STRIDE) + STOP_OFS;
        end else begin
            s        = i - 1 - num_sections;
            cmd.addr = ADDR_W'(s * SECTION_STRIDE) + GO_OFS;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/perf_trig_arbiter.sv
// Fixed-priority encoder over the pending-event flags; lowest index wins.
// Ports:
//   pending      - pending flag vector
//   grant_c      - one-hot grant of the winning flag (zero when none pending)
//   grant_idx_c  - index of the winning flag
//   any_c        - at least one flag pending
module perf_trig_arbiter
    import perf_trig_pkg::*;
#(
    parameter int unsigned PEND_W = 7
) (
    input  logic [PEND_W-1:0]    pending,
    output logic [PEND_W-1:0]    grant_c,
    output logic [CMD_IDX_W-1:0] grant_idx_c,
    output logic                 any_c
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = |pending;
        for (int i = PEND_W - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_c     = '0;
                grant_c[i]  = 1'b1;
                grant_idx_c = CMD_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/perf_counter_trigger_master.sv
// Avalon-MM write master turning hardware start/stop/clear pulses into
// go/stop writes on the performance-counter control slave.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start_pulse[s]      - request a "go" write for section s
//   stop_pulse[s]       - request a "stop" write for section s
//   clear_pulse         - request a global counter reset write
//   clear_status        - clear overflow and drop_count
//   avm_*               - Avalon-MM write master port
//   busy                - transfer in flight or event pending
//   overflow            - sticky, an event was dropped
//   drop_count          - saturating number of dropped events
module perf_counter_trigger_master
    import perf_trig_pkg::*;
#(
    parameter int unsigned NUM_SECTIONS = 3,
    parameter int unsigned DROP_CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] start_pulse,
    input  logic [NUM_SECTIONS-1:0] stop_pulse,
    input  logic                    clear_pulse,
    input  logic                    clear_status,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_write,
    output logic                    avm_begintransfer,
    output logic [DATA_W-1:0]       avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int unsigned PEND_W = 2 * NUM_SECTIONS + 1;
    localparam int unsigned SUM_W  = DROP_CNT_W + 1;

    trig_state_e          state, state_nxt;
    logic [PEND_W-1:0]    pending, pending_nxt;
    logic [PEND_W-1:0]    pulse_vec;
    logic [PEND_W-1:0]    arb_grant_c;
    logic [CMD_IDX_W-1:0] arb_idx_c;
    logic                 arb_any_c;
    logic [PEND_W-1:0]    take_mask;
    logic [PEND_W-1:0]    drop_vec;
    logic [CMD_IDX_W-1:0] drop_num;
    logic [DROP_CNT_W-1:0] drop_base;
    logic [SUM_W-1:0]     drop_sum;
    logic [DROP_CNT_W-1:0] drop_count_nxt;
    logic                 overflow_nxt;
    logic                 write_nxt;
    logic                 begin_nxt;
    avm_cmd_t             cmd_nxt;
    avm_cmd_t             cmd_dec;

    assign pulse_vec = {start_pulse, stop_pulse, clear_pulse};

    perf_trig_arbiter #(
        .PEND_W (PEND_W)
    ) u_arbiter (
        .pending     (pending),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    assign cmd_dec = decode_cmd(arb_idx_c, NUM_SECTIONS);

    // Pending flags: grant clears only in IDLE; a pulse on a flag that is
    // being granted re-queues it, a pulse on any other set flag is a drop.
    always_comb begin
        take_mask   = (state == ST_IDLE) ? arb_grant_c : '0;
        drop_vec    = pulse_vec & pending & ~take_mask;
        pending_nxt = (pending & ~take_mask) | pulse_vec;
    end

    // Status: a drop in the same cycle as clear_status survives the clear.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < PEND_W; i++) begin
            drop_num = drop_num + CMD_IDX_W'(drop_vec[i]);
        end
        drop_base      = clear_status ? '0 : drop_count;
        drop_sum       = {1'b0, drop_base} + SUM_W'(drop_num);
        drop_count_nxt = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        overflow_nxt   = (overflow & ~clear_status) | (|drop_vec);
    end

    // Next state and next registered Avalon outputs.
    always_comb begin
        state_nxt = state;
        write_nxt = avm_write;
        begin_nxt = 1'b0;
        cmd_nxt   = '{addr: avm_address, data: avm_writedata};
        case (state)
            ST_IDLE: begin
                write_nxt = 1'b0;
                if (arb_any_c) begin
                    state_nxt = ST_FIRST;
                    write_nxt = 1'b1;
                    begin_nxt = 1'b1;
                    cmd_nxt   = cmd_dec;
                end
            end
            ST_FIRST: begin
                if (!avm_waitrequest) begin
                    state_nxt = ST_IDLE;
                    write_nxt = 1'b0;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!avm_waitrequest) begin
                    state_nxt = ST_IDLE;
                    write_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                write_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, pending flags and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending           <= '0;
            avm_address       <= '0;
            avm_writedata     <= '0;
            avm_write         <= 1'b0;
            avm_begintransfer <= 1'b0;
            busy              <= 1'b0;
            overflow          <= 1'b0;
            drop_count        <= '0;
        end else begin
            pending           <= pending_nxt;
            avm_address       <= cmd_nxt.addr;
            avm_writedata     <= cmd_nxt.data;
            avm_write         <= write_nxt;
            avm_begintransfer <= begin_nxt;
            busy              <= (state_nxt != ST_IDLE) || (|pending_nxt);
            overflow          <= overflow_nxt;
            drop_count        <= drop_count_nxt;
        end
    end

endmodule

// File: tb/tb_perf_counter_trigger_master.sv
// Directed self-checking bench for perf_counter_trigger_master.
module tb_perf_counter_trigger_master;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] start_pulse = '0;
    logic [NS-1:0] stop_pulse = '0;
    logic          clear_pulse = 1'b0;
    logic          clear_status = 1'b0;
    logic [3:0]    avm_address;
    logic          avm_write;
    logic          avm_begintransfer;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest = 1'b0;
    logic          busy;
    logic          overflow;
    logic [DW-1:0] drop_count;

    perf_counter_trigger_master #(
        .NUM_SECTIONS (NS),
        .DROP_CNT_W   (DW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_pulse       (start_pulse),
        .stop_pulse        (stop_pulse),
        .clear_pulse       (clear_pulse),
        .clear_status      (clear_status),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_begintransfer (avm_begintransfer),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .busy              (busy),
        .overflow          (overflow),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t xq[$];
    int    cyc_cnt = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    // Record every accepted write with its edge number.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (reset_n && avm_write && !avm_waitrequest)
            xq.push_back('{cyc_cnt, avm_address, avm_writedata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n, input string tag);
        int k = 0;
        while (xq.size() < n && k < 50) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(xq.size()), 32'(n));
    endtask

    task automatic check_xfer(input int idx, input logic [3:0] a, input logic [31:0] d, input string tag);
        if (idx < xq.size()) begin
            check_eq({tag, "_addr"}, 32'(xq[idx].addr), 32'(a));
            check_eq({tag, "_data"}, xq[idx].data, d);
        end else begin
            check_eq({tag, "_missing"}, 32'(xq.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n_wr;
        int n_bt;
        int n_before;
        logic bad_addr;

        // Reset
        tick(3);
        reset_n = 1'b1;
        tick();
        check_eq("rst_write", 32'(avm_write), 0);
        check_eq("rst_bt", 32'(avm_begintransfer), 0);
        check_eq("rst_addr", 32'(avm_address), 0);
        check_eq("rst_data", avm_writedata, 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        check_eq("rst_drops", 32'(drop_count), 0);

        // 1: single start[1], cycle-exact timing
        start_pulse = 3'b010;
        tick();
        start_pulse = '0;
        check_eq("t1_write_e1", 32'(avm_write), 0);
        check_eq("t1_busy_e1", 32'(busy), 1);
        tick();
        check_eq("t1_write_e2", 32'(avm_write), 1);
        check_eq("t1_bt_e2", 32'(avm_begintransfer), 1);
        check_eq("t1_addr", 32'(avm_address), 5);
        check_eq("t1_data", avm_writedata, 0);
        tick();
        check_eq("t1_write_e3", 32'(avm_write), 0);
        check_eq("t1_bt_e3", 32'(avm_begintransfer), 0);
        check_eq("t1_busy_e3", 32'(busy), 0);
        tick(2);
        check_eq("t1_count", 32'(xq.size()), 1);
        xq.delete();

        // 2: start[0] + stop[2] together -> stop first, one IDLE gap
        start_pulse = 3'b001;
        stop_pulse  = 3'b100;
        tick();
        start_pulse = '0;
        stop_pulse  = '0;
        wait_xfers(2, "t2_count");
        check_xfer(0, 4'd8, 32'h0, "t2_first");
        check_xfer(1, 4'd1, 32'h0, "t2_second");
        if (xq.size() >= 2)
            check_eq("t2_gap", 32'(xq[1].cyc - xq[0].cyc), 2);
        tick(3);
        xq.delete();

        // 3: clear + start[0] -> clear first
        clear_pulse = 1'b1;
        start_pulse = 3'b001;
        tick();
        clear_pulse = 1'b0;
        start_pulse = '0;
        wait_xfers(2, "t3_count");
        check_xfer(0, 4'd0, 32'h1, "t3_first");
        check_xfer(1, 4'd1, 32'h0, "t3_second");
        tick(3);
        xq.delete();

        // 4: stop[1] with waitrequest high for 5 edges
        avm_waitrequest = 1'b1;
        stop_pulse = 3'b010;
        tick();
        stop_pulse = '0;
        n_wr = 0;
        n_bt = 0;
        bad_addr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (avm_write) begin
                n_wr++;
                if (avm_begintransfer) n_bt++;
                if (avm_address != 4'd4) bad_addr = 1'b1;
                if (n_wr == 6) avm_waitrequest = 1'b0;
            end else if (n_wr > 0) begin
                break;
            end
        end
        avm_waitrequest = 1'b0;
        check_eq("t4_write_cycles", 32'(n_wr), 6);
        check_eq("t4_bt_cycles", 32'(n_bt), 1);
        check_eq("t4_addr_stable", 32'(bad_addr), 0);
        check_eq("t4_count", 32'(xq.size()), 1);
        check_xfer(0, 4'd4, 32'h0, "t4_xfer");
        tick(2);
        xq.delete();

        // 5: re-queue at grant edge is not a drop (start[0] held 2 cycles)
        start_pulse = 3'b001;
        tick(2);
        start_pulse = '0;
        wait_xfers(2, "t5_count");
        check_xfer(0, 4'd1, 32'h0, "t5_first");
        check_xfer(1, 4'd1, 32'h0, "t5_second");
        check_eq("t5_ovf", 32'(overflow), 0);
        check_eq("t5_drops", 32'(drop_count), 0);
        tick(3);
        xq.delete();

        // 6: start[2] three times while a stop[0] write is stalled
        avm_waitrequest = 1'b1;
        stop_pulse = 3'b001;
        tick();
        stop_pulse = '0;
        tick(3);
        for (int k = 0; k < 3; k++) begin
            start_pulse = 3'b100;
            tick();
            start_pulse = '0;
            tick();
        end
        check_eq("t6_ovf", 32'(overflow), 1);
        check_eq("t6_drops", 32'(drop_count), 2);
        check_eq("t6_busy", 32'(busy), 1);
        avm_waitrequest = 1'b0;
        wait_xfers(2, "t6_count");
        check_xfer(0, 4'd0, 32'h0, "t6_first");
        check_xfer(1, 4'd9, 32'h0, "t6_second");
        tick(6);
        check_eq("t6_no_extra", 32'(xq.size()), 2);
        check_eq("t6_idle_busy", 32'(busy), 0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check_eq("t6_clr_ovf", 32'(overflow), 0);
        check_eq("t6_clr_drops", 32'(drop_count), 0);
        xq.delete();

        // 7: asynchronous reset during HOLD with another event pending
        avm_waitrequest = 1'b1;
        start_pulse = 3'b001;
        tick();
        start_pulse = '0;
        tick(2);
        stop_pulse = 3'b010;
        tick();
        stop_pulse = '0;
        check_eq("t7_hold_write", 32'(avm_write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t7_rst_write", 32'(avm_write), 0);
        check_eq("t7_rst_bt", 32'(avm_begintransfer), 0);
        check_eq("t7_rst_addr", 32'(avm_address), 0);
        check_eq("t7_rst_busy", 32'(busy), 0);
        n_before = xq.size();
        tick(2);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick(10);
        check_eq("t7_no_write", 32'(xq.size()), 32'(n_before));
        check_eq("t7_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
